prog_mem_arbiter: RTL and testbench
===================================

// Module: prog_mem_arbiter
// PURPOSE
//  Shares the single-port, combinational-read program memory between two requesters.
//  - CPU instruction-fetch port: read-only.
//  - Loader/debug port: read/write, with an exclusive-lock mode used for boot image load.
//  Bounded-starvation priority arbitration; one access per cycle; registered read return.
//  Fetch data is byte-swapped from image order to CPU order.
// PARAMETERS
//  ADDR_WIDTH      11  byte-address width of both requester ports
//  DATA_WIDTH      32  word width (byte swap defined for 32 only)
//  MAX_FETCH_BURST 4   consecutive contended fetch grants before loader is forced through (>=1)
//  BIG_END_IMG     0   1: fetch data returned raw; 0: fetch data byte-reversed
// PORTS
//  clk        in  1           clock, all state on rising edge
//  rst        in  1           reset: asynchronous, active-high
//  f_req      in  1           fetch request, held until granted
//  f_addr     in  ADDR_WIDTH  fetch byte address
//  f_gnt      out 1           fetch accepted this cycle (combinational)
//  f_rvalid   out 1           fetch data valid (1 cycle after grant)
//  f_rdata    out DATA_WIDTH  fetch data
//  l_req      in  1           loader request, held until granted
//  l_we       in  1           loader write (1) / read (0)
//  l_addr     in  ADDR_WIDTH  loader byte address
//  l_wdata    in  DATA_WIDTH  loader write data, image byte order
//  l_lock     in  1           loader requests exclusive ownership
//  l_gnt      out 1           loader accepted this cycle (combinational)
//  l_rvalid   out 1           loader read data valid (reads only)
//  l_rdata    out DATA_WIDTH  loader read data, raw image order
//  locked     out 1           arbiter in LOCK state
//  mem_addr   out ADDR_WIDTH-2 word address to memory (combinational)
//  mem_we     out 1           memory write strobe (combinational)
//  mem_wdata  out DATA_WIDTH  memory write data
//  mem_rdata  in  DATA_WIDTH  memory read data, combinational from mem_addr
//  err_misal  out 1           sticky: an accepted access had addr[1:0]!=0
// BEHAVIOUR
//  Reset (async, any cycle): state=SHARE; fcnt=0.
//    All outputs 0: rvalid, rdata, locked, err_misal.
//    In-flight rvalid is dropped and not replayed.
//  Accept = req && gnt in cycle N:
//    - Memory accessed in cycle N at mem_addr = addr >> 2 (misaligned accesses aligned down).
//    - Read data registered; rvalid pulses high exactly in cycle N+1.
//    - rdata holds its value until the next read returns.
//  Writes: mem_we=1 only in the accept cycle; no rvalid; mem_wdata=l_wdata unmodified.
//  Idle cycles: mem_we=0, mem_addr=0.
//  FSM SHARE (locked=0):
//    - Only f_req -> f_gnt; only l_req -> l_gnt; neither -> no grant.
//    - Both requesting, fcnt<MAX_FETCH_BURST -> f_gnt, fcnt++.
//    - Both requesting, fcnt==MAX_FETCH_BURST -> l_gnt, fcnt=0.
//    - fcnt clears whenever l_req=0 or loader is granted.
//    - l_lock=1 at the clock edge -> LOCK next cycle; a grant in that same cycle still completes.
//  FSM LOCK (locked=1):
//    - f_gnt=0; l_gnt=l_req.
//    - l_lock=0 at the clock edge -> SHARE with fcnt=0.
//  f_gnt and l_gnt are never both 1 in the same cycle.
//  f_rdata: BIG_END_IMG=0 -> {m[7:0],m[15:8],m[23:16],m[31:24]}; BIG_END_IMG=1 -> raw.
//  err_misal: set on any accept with addr[1:0]!=0; cleared only by rst.
//  Back-to-back accepts every cycle sustained; no bubble between grants.
// TESTING
//  1 Reset: assert rst mid-read -> next cycle f_rvalid=0, locked=0, err_misal=0; no late rvalid.
//  2 Fetch only: f_addr=0x008, mem word2=0x13050000
//      -> f_gnt same cycle, mem_addr=2; next cycle f_rvalid=1, f_rdata=0x00000513.
//  3 Contention: f_req and l_req held high, MAX_FETCH_BURST=4
//      -> grants F,F,F,F,L,F,F,F,F,L...; never both granted in one cycle.
//  4 Lock load: l_lock=1; write 0xDEADBEEF to 0x010 while f_req=1
//      -> f_gnt=0, mem_we=1, mem_addr=4; drop l_lock -> fetch granted next cycle.
//  5 Loader readback: read 0x010 -> l_rvalid next cycle, l_rdata=0xDEADBEEF (raw order).
//  6 Misaligned: fetch 0x00A -> mem_addr=2, err_misal=1 and stays 1 until rst.

Source files
------------

// File: rtl/prog_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// prog_mem_arbiter_if
//   Bundles every bus signal around the program-memory arbiter: the CPU fetch
//   port, the loader/debug port, the memory port and the status flags.
//   Modports:
//     slave  - the arbiter's view (requests and mem_rdata in; grants, return
//              data, memory strobes and status out)
//     master - the environment's view (requesters plus the memory model)
//   Signals:
//     f_req/f_addr -> f_gnt, f_rvalid, f_rdata     fetch port (read-only)
//     l_req/l_we/l_addr/l_wdata/l_lock -> l_gnt, l_rvalid, l_rdata  loader port
//     mem_addr/mem_we/mem_wdata -> mem_rdata       single-port memory
//     locked, err_misal                            status
// ---------------------------------------------------------------------------
interface prog_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  // fetch port
  logic                  f_req;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_gnt;
  logic                  f_rvalid;
  logic [DATA_WIDTH-1:0] f_rdata;
  // loader port
  logic                  l_req;
  logic                  l_we;
  logic [ADDR_WIDTH-1:0] l_addr;
  logic [DATA_WIDTH-1:0] l_wdata;
  logic                  l_lock;
  logic                  l_gnt;
  logic                  l_rvalid;
  logic [DATA_WIDTH-1:0] l_rdata;
  // memory port
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  // status
  logic                  locked;
  logic                  err_misal;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           mem_addr, mem_we, mem_wdata, locked, err_misal
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           mem_addr, mem_we, mem_wdata, locked, err_misal
  );
endinterface

// File: rtl/prog_mem_arbiter.sv
// ---------------------------------------------------------------------------
// prog_mem_arbiter
//   Shares a single-port, combinational-read program memory between the CPU
//   instruction-fetch port (read-only) and the loader/debug port (read/write,
//   with an exclusive lock used while loading a boot image).
//   - One access per cycle, grants are combinational, read data is registered
//     and returned with rvalid exactly one cycle after the grant.
//   - Under contention fetch wins up to MAX_FETCH_BURST times in a row, then
//     the loader is forced through once.
//   - Fetch data is byte-reversed from image order to CPU order unless
//     BIG_END_IMG is set; loader data is always raw image order.
//   Ports:
//     clk  - clock, all state on the rising edge
//     rst  - asynchronous, active-high reset
//     bus  - prog_mem_arbiter_if.slave (fetch, loader, memory, status)
// ---------------------------------------------------------------------------
module prog_mem_arbiter #(
  parameter int ADDR_WIDTH      = 11,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_FETCH_BURST = 4,
  parameter bit BIG_END_IMG     = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  prog_mem_arbiter_if.slave    bus
);

  typedef enum logic {
    SHARE = 1'b0,
    LOCK  = 1'b1
  } state_t;

  localparam int              CW        = $clog2(MAX_FETCH_BURST + 1);
  localparam logic [CW-1:0]   BURST_MAX = CW'(MAX_FETCH_BURST);

  state_t                state;
  logic [CW-1:0]         fcnt;      // consecutive contended fetch grants
  logic                  f_gnt;
  logic                  l_gnt;
  logic                  l_rd;      // loader read accepted this cycle
  logic                  misal;
  logic [DATA_WIDTH-1:0] f_word;    // memory word in CPU byte order

  logic                  f_rvalid_q;
  logic                  l_rvalid_q;
  logic [DATA_WIDTH-1:0] f_rdata_q;
  logic [DATA_WIDTH-1:0] l_rdata_q;
  logic                  locked_q;
  logic                  err_q;

  // Grant selection. The two grants are mutually exclusive on every path.
  always_comb begin
    // NOTE: defaults first so every path assigns each output; no latch can be inferred.
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (state == LOCK) begin
      l_gnt = bus.l_req;
    end else if (bus.f_req && bus.l_req) begin
      if (fcnt >= BURST_MAX) l_gnt = 1'b1;
      else                   f_gnt = 1'b1;
    end else begin
      f_gnt = bus.f_req;
      l_gnt = bus.l_req;
    end
  end

  // Memory port: word address of the granted requester, zero when idle.
  always_comb begin
    bus.mem_addr = '0;
    bus.mem_we   = 1'b0;
    if (f_gnt) begin
      bus.mem_addr = bus.f_addr[ADDR_WIDTH-1:2];
    end else if (l_gnt) begin
      bus.mem_addr = bus.l_addr[ADDR_WIDTH-1:2];
      bus.mem_we   = bus.l_we;
    end
  end

  assign bus.mem_wdata = bus.l_wdata;

  // Image order -> CPU order for fetch returns.
  always_comb begin
    f_word = bus.mem_rdata;
    if (!BIG_END_IMG) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        f_word[8*b +: 8] = bus.mem_rdata[DATA_WIDTH-8-8*b +: 8];
      end
    end
  end

  assign l_rd  = l_gnt && !bus.l_we;
  assign misal = (f_gnt && (bus.f_addr[1:0] != 2'b00)) ||
                 (l_gnt && (bus.l_addr[1:0] != 2'b00));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SHARE;
      fcnt       <= '0;
      locked_q   <= 1'b0;
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      l_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
      f_rvalid_q <= f_gnt;
      l_rvalid_q <= l_rd;
      if (f_gnt) f_rdata_q <= f_word;
      if (l_rd)  l_rdata_q <= bus.mem_rdata;
      if (misal) err_q     <= 1'b1;

      case (state)
        SHARE: begin
          // The burst count only runs while the loader is actually waiting.
          if (!bus.l_req || l_gnt) fcnt <= '0;
          else if (f_gnt)          fcnt <= fcnt + 1'b1;
          if (bus.l_lock) begin
            state    <= LOCK;
            locked_q <= 1'b1;
          end
        end
        LOCK: begin
          fcnt <= '0;
          if (!bus.l_lock) begin
            state    <= SHARE;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state    <= SHARE;
          locked_q <= 1'b0;
          fcnt     <= '0;
        end
      endcase
    end
  end

  assign bus.f_gnt     = f_gnt;
  assign bus.l_gnt     = l_gnt;
  assign bus.f_rvalid  = f_rvalid_q;
  assign bus.l_rvalid  = l_rvalid_q;
  assign bus.f_rdata   = f_rdata_q;
  assign bus.l_rdata   = l_rdata_q;
  assign bus.locked    = locked_q;
  assign bus.err_misal = err_q;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_prog_mem_arbiter
//   Directed, table-driven bench for prog_mem_arbiter (MAX_FETCH_BURST=4,
//   BIG_END_IMG=0). A word-array memory model sits on the memory port.
//   Each vector is driven just after a rising edge; grants and memory strobes
//   are sampled mid-cycle, registered outputs just after the next edge.
// ---------------------------------------------------------------------------
module tb_prog_mem_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  prog_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  prog_mem_arbiter #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_FETCH_BURST (4),
    .BIG_END_IMG     (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // NOTE: the memory array has no reset; contents are preloaded once and survive rst like real RAM.
  logic [DW-1:0] mem [0:(1<<(AW-2))-1];

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_f_rdata;
  logic [DW-1:0] exp_l_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        f_req;
    logic [10:0] f_addr;
    logic        l_req;
    logic        l_we;
    logic [10:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_lock;
    logic        e_fg;
    logic        e_lg;
    logic [8:0]  e_maddr;
    logic        e_mwe;
    logic        e_fv;
    logic [31:0] e_frd;
    logic        e_lv;
    logic [31:0] e_lrd;
    logic        e_locked;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(
    input logic f_req, input logic [10:0] f_addr,
    input logic l_req, input logic l_we, input logic [10:0] l_addr,
    input logic [31:0] l_wdata, input logic l_lock,
    input logic e_fg, input logic e_lg, input logic [8:0] e_maddr, input logic e_mwe,
    input logic e_fv, input logic [31:0] e_frd, input logic e_lv, input logic [31:0] e_lrd,
    input logic e_locked, input logic e_err);
    vec_t v;
    v.f_req = f_req;   v.f_addr = f_addr;
    v.l_req = l_req;   v.l_we = l_we;     v.l_addr = l_addr;
    v.l_wdata = l_wdata; v.l_lock = l_lock;
    v.e_fg = e_fg;     v.e_lg = e_lg;     v.e_maddr = e_maddr; v.e_mwe = e_mwe;
    v.e_fv = e_fv;     v.e_frd = e_frd;   v.e_lv = e_lv;       v.e_lrd = e_lrd;
    v.e_locked = e_locked; v.e_err = e_err;
    return v;
  endfunction

  task automatic drive(input logic f_req, input logic [10:0] f_addr,
                       input logic l_req, input logic l_we, input logic [10:0] l_addr,
                       input logic [31:0] l_wdata, input logic l_lock);
    bus.f_req   = f_req;
    bus.f_addr  = f_addr;
    bus.l_req   = l_req;
    bus.l_we    = l_we;
    bus.l_addr  = l_addr;
    bus.l_wdata = l_wdata;
    bus.l_lock  = l_lock;
  endtask

  // Entered and left at posedge+1.
  task automatic apply(input vec_t v, input int idx);
    drive(v.f_req, v.f_addr, v.l_req, v.l_we, v.l_addr, v.l_wdata, v.l_lock);
    #4;
    check($sformatf("v%0d f_gnt", idx),    bus.f_gnt,    v.e_fg);
    check($sformatf("v%0d l_gnt", idx),    bus.l_gnt,    v.e_lg);
    check($sformatf("v%0d both_gnt", idx), bus.f_gnt & bus.l_gnt, 0);
    check($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.e_maddr);
    check($sformatf("v%0d mem_we", idx),   bus.mem_we,   v.e_mwe);
    if (v.e_mwe) check($sformatf("v%0d mem_wdata", idx), bus.mem_wdata, v.l_wdata);
    @(posedge clk);
    #1;
    if (v.e_fv) exp_f_rdata = v.e_frd;
    if (v.e_lv) exp_l_rdata = v.e_lrd;
    check($sformatf("v%0d f_rvalid", idx),  bus.f_rvalid,  v.e_fv);
    check($sformatf("v%0d l_rvalid", idx),  bus.l_rvalid,  v.e_lv);
    check($sformatf("v%0d f_rdata", idx),   bus.f_rdata,   exp_f_rdata);
    check($sformatf("v%0d l_rdata", idx),   bus.l_rdata,   exp_l_rdata);
    check($sformatf("v%0d locked", idx),    bus.locked,    v.e_locked);
    check($sformatf("v%0d err_misal", idx), bus.err_misal, v.e_err);
  endtask

  vec_t vecs[$];

  initial begin
    for (int i = 0; i < (1 << (AW-2)); i++) mem[i] = '0;
    mem[2] = 32'h1305_0000;
    mem[3] = 32'h1122_3344;
    mem[5] = 32'hA1B2_C3D4;

    //              f_req f_addr  l_req we l_addr  l_wdata       lock | fg lg maddr we | fv frd           lv lrd           lk err
    vecs.push_back(mk(0, 11'h000, 0, 0, 11'h000, 32'h0,         0,    0, 0, 9'd0, 0,   0, 32'h0,         0, 32'h0,         0, 0)); // idle
    vecs.push_back(mk(1, 11'h008, 0, 0, 11'h000, 32'h0,         0,    1, 0, 9'd2, 0,   1, 32'h0000_0513, 0, 32'h0,         0, 0)); // fetch + swap
    vecs.push_back(mk(1, 11'h00C, 0, 0, 11'h000, 32'h0,         0,    1, 0, 9'd3, 0,   1, 32'h4433_2211, 0, 32'h0,         0, 0));
    vecs.push_back(mk(0, 11'h000, 1, 0, 11'h014, 32'h0,         0,    0, 1, 9'd5, 0,   0, 32'h0,         1, 32'hA1B2_C3D4, 0, 0)); // loader read raw
    for (int k = 0; k < 4; k++)                                                                                                           // contention F x4
      vecs.push_back(mk(1, 11'h008, 1, 0, 11'h00C, 32'h0,       0,    1, 0, 9'd2, 0,   1, 32'h0000_0513, 0, 32'h0,         0, 0));
    vecs.push_back(mk(1, 11'h008, 1, 0, 11'h00C, 32'h0,         0,    0, 1, 9'd3, 0,   0, 32'h0,         1, 32'h1122_3344, 0, 0)); // forced L
    vecs.push_back(mk(1, 11'h008, 1, 0, 11'h00C, 32'h0,         0,    1, 0, 9'd2, 0,   1, 32'h0000_0513, 0, 32'h0,         0, 0)); // F again
    vecs.push_back(mk(1, 11'h008, 1, 1, 11'h010, 32'hDEADBEEF,  1,    1, 0, 9'd2, 0,   1, 32'h0000_0513, 0, 32'h0,         1, 0)); // lock edge, fetch completes
    vecs.push_back(mk(1, 11'h008, 1, 1, 11'h010, 32'hDEADBEEF,  1,    0, 1, 9'd4, 1,   0, 32'h0,         0, 32'h0,         1, 0)); // locked write
    vecs.push_back(mk(1, 11'h008, 0, 0, 11'h000, 32'h0,         0,    0, 0, 9'd0, 0,   0, 32'h0,         0, 32'h0,         0, 0)); // drop lock
    vecs.push_back(mk(1, 11'h008, 0, 0, 11'h000, 32'h0,         0,    1, 0, 9'd2, 0,   1, 32'h0000_0513, 0, 32'h0,         0, 0)); // fetch resumes
    vecs.push_back(mk(0, 11'h000, 1, 0, 11'h010, 32'h0,         0,    0, 1, 9'd4, 0,   0, 32'h0,         1, 32'hDEADBEEF,  0, 0)); // readback raw
    vecs.push_back(mk(1, 11'h010, 0, 0, 11'h000, 32'h0,         0,    1, 0, 9'd4, 0,   1, 32'hEFBEADDE,  0, 32'h0,         0, 0)); // fetch swapped
    vecs.push_back(mk(1, 11'h00A, 0, 0, 11'h000, 32'h0,         0,    1, 0, 9'd2, 0,   1, 32'h0000_0513, 0, 32'h0,         0, 1)); // misaligned
    vecs.push_back(mk(0, 11'h000, 0, 0, 11'h000, 32'h0,         0,    0, 0, 9'd0, 0,   0, 32'h0,         0, 32'h0,         0, 1)); // sticky
    vecs.push_back(mk(0, 11'h000, 1, 1, 11'h015, 32'h0000_0055, 0,    0, 1, 9'd5, 1,   0, 32'h0,         0, 32'h0,         0, 1)); // misaligned write
    vecs.push_back(mk(0, 11'h000, 1, 0, 11'h014, 32'h0,         0,    0, 1, 9'd5, 0,   0, 32'h0,         1, 32'h0000_0055, 0, 1));

    // Reset state.
    rst = 1'b1;
    drive(0, '0, 0, 0, '0, '0, 0);
    exp_f_rdata = '0;
    exp_l_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst f_rvalid", bus.f_rvalid,  0);
    check("rst l_rvalid", bus.l_rvalid,  0);
    check("rst f_rdata",  bus.f_rdata,   0);
    check("rst l_rdata",  bus.l_rdata,   0);
    check("rst locked",   bus.locked,    0);
    check("rst err",      bus.err_misal, 0);
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i], i);

    // Reset in the middle of a locked loader read.
    drive(0, '0, 0, 0, '0, '0, 1);
    @(posedge clk); #1;
    check("pre-rst locked", bus.locked, 1);
    drive(0, '0, 1, 0, 11'h010, '0, 1);
    #2;
    check("pre-rst l_gnt", bus.l_gnt, 1);
    #1 rst = 1'b1;
    #1;
    check("async locked", bus.locked,    0);
    check("async err",    bus.err_misal, 0);
    check("async l_rdata", bus.l_rdata,  0);
    @(posedge clk); #1;
    check("rst l_rvalid mid", bus.l_rvalid, 0);
    check("rst f_rvalid mid", bus.f_rvalid, 0);
    check("rst locked mid",   bus.locked,   0);
    drive(0, '0, 0, 0, '0, '0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("no late l_rvalid", bus.l_rvalid, 0);

    // Reset in the middle of a fetch.
    drive(1, 11'h008, 0, 0, '0, '0, 0);
    #2;
    check("pre-rst f_gnt", bus.f_gnt, 1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("rst f_rvalid fetch", bus.f_rvalid, 0);
    check("rst f_rdata fetch",  bus.f_rdata,  0);
    drive(0, '0, 0, 0, '0, '0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("no late f_rvalid", bus.f_rvalid,  0);
    check("err after rst",    bus.err_misal, 0);

    // Sustained contention from fcnt=0: F,F,F,F,L repeating, no bubbles.
    for (int k = 0; k < 15; k++) begin
      drive(1, 11'h00C, 1, 0, 11'h008, '0, 0);
      #4;
      check($sformatf("cont%0d f_gnt", k), bus.f_gnt, (k % 5) != 4);
      check($sformatf("cont%0d l_gnt", k), bus.l_gnt, (k % 5) == 4);
      @(posedge clk); #1;
      check($sformatf("cont%0d f_rvalid", k), bus.f_rvalid, (k % 5) != 4);
      check($sformatf("cont%0d l_rvalid", k), bus.l_rvalid, (k % 5) == 4);
      if ((k % 5) == 4) check($sformatf("cont%0d l_rdata", k), bus.l_rdata, 32'h1305_0000);
      else              check($sformatf("cont%0d f_rdata", k), bus.f_rdata, 32'h4433_2211);
    end

    drive(0, '0, 0, 0, '0, '0, 0);
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
